up_down_counter_param: RTL and testbench
========================================

// Module: up_down_counter_param
// PURPOSE
// - Parametrised successor to the 8-bit up/down counter: WIDTH-bit counter bounded to [0, MAX_VAL].
// - Adds: count step b, parallel load of a, selectable wrap/saturate mode, bound flags,
//   one-cycle wrap pulse and a sticky overflow flag.
// - Serves as the reusable counter primitive for the operations/unsigned designs.
// PARAMETERS
// - WIDTH     8              counter, a and b width in bits (>=2)
// - MAX_VAL   2**WIDTH-1     upper bound of q (1..2**WIDTH-1)
// - SATURATE  0              0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL
// PORTS
// - clk       in   1      single clock; all state updates on rising edge
// - rst       in   1      asynchronous, active-low reset (0 = reset asserted)
// - en        in   1      count enable; does not gate load
// - load      in   1      synchronous load of a into q
// - a         in   WIDTH  load value
// - b         in   WIDTH  step size, unsigned
// - up        in   1      count up by b
// - dn        in   1      count down by b
// - clr_ovf   in   1      synchronous clear of ovf
// - q         out  WIDTH  counter value (registered)
// - at_max    out  1      q == MAX_VAL (combinational decode of q)
// - at_min    out  1      q == 0 (combinational decode of q)
// - wrap      out  1      one-cycle pulse: a bound was crossed or hit-and-clamped
// - ovf       out  1      sticky: set by any wrap pulse, cleared by clr_ovf or reset
// BEHAVIOUR
// - Reset (rst=0, async): q=0, wrap=0, ovf=0; at_min=1, at_max=0 follow.
// - Reset mid-count: state clears immediately. First update occurs on the first rising edge
//   after rst returns to 1.
// - Priority per edge: load > count > hold.
//   - load=1: q <= min(a, MAX_VAL); wrap <= 0.
//   - Else en=1 and exactly one of up/dn: count by b_eff = min(b, MAX_VAL).
//   - Else (en=0, up=dn=0, or up=dn=1): hold; wrap <= 0.
// - Latency: q, wrap and ovf all update on the same edge that samples the inputs (1 cycle).
// - Up count: compute s = q + b_eff in WIDTH+1 bits.
//   - s <= MAX_VAL: q <= s.
//   - Otherwise, wrap mode: q <= s - (MAX_VAL+1); saturate mode: q <= MAX_VAL. wrap <= 1 in both modes.
// - Down count:
//   - b_eff <= q: q <= q - b_eff.
//   - Otherwise, wrap mode: q <= q + (MAX_VAL+1) - b_eff; saturate mode: q <= 0. wrap <= 1.
// - b = 0 while counting: q unchanged, wrap=0.
// - Saturate mode at a bound: further steps into the bound keep q there and pulse wrap on every
//   such cycle.
// - ovf: set on any edge where wrap is being set. clr_ovf=1 clears ovf; if a new wrap occurs on
//   the same edge, set wins.
// - All intermediate arithmetic is unsigned, WIDTH+1 bits. No signed interpretation of a or b.
// STRUCTURE
// - Package up_down_counter_pkg: mode constants MODE_WRAP=0, MODE_SAT=1; ctl encoding
//   {HOLD, UP, DN, LOAD} as a 2-bit typedef.
// - Sub-module step_unit (combinational):
//   - Inputs: q, b_eff, dir, mode.
//   - Outputs: next value and crossed flag.
//   - The top level holds the q/wrap/ovf registers, priority decode and flags.
// TESTING
// - Reset: rst=0 while up=1, en=1 -> q=0, at_min=1, wrap=0, ovf=0. Release rst -> q=b on the
//   next edge.
// - Wrap up (WIDTH=8, MAX_VAL=255, SATURATE=0): load 250, then up, b=10 -> q=4, wrap=1 for
//   1 cycle, ovf=1 held.
// - Wrap down (same config): q=3, dn, b=5 -> q=254, wrap pulse. Next cycle b=0 -> q=254, wrap=0.
// - Saturate (SATURATE=1, MAX_VAL=100): load 95, up, b=10 -> q=100, at_max=1, wrap=1. Repeat
//   -> q=100, wrap=1. Then dn, b=200 -> q=0, at_min=1.
// - Priority/idle: load=1, up=1, a=300 (WIDTH=9, MAX_VAL=300) -> q=300.
//   - up=dn=1 -> hold.
//   - en=0 -> hold.
//   - clr_ovf=1 on the same edge as a wrap -> ovf stays 1.
// - Random: 1000 cycles of random a, b, up, dn, en, load, clr_ovf against a reference model,
//   for both modes. Include async rst pulses between clock edges; check q=0 immediately.

Source files
------------

// File: rtl/up_down_counter_pkg.sv
// rtl/up_down_counter_pkg.sv - shared mode constants and control encoding for the up/down counter
package up_down_counter_pkg;

  // Counting behaviour when a step would leave [0, MAX_VAL]
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Per-edge action chosen by the top-level priority decode
  typedef enum logic [1:0] {
    CTL_HOLD = 2'd0,
    CTL_UP   = 2'd1,
    CTL_DN   = 2'd2,
    CTL_LOAD = 2'd3
  } ctl_e;

endpackage

// File: rtl/step_unit.sv
// rtl/step_unit.sv - combinational next-value and bound-crossing computation for one count step
module step_unit
  import up_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] b_eff,
  input  ctl_e             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] nxt,
  output logic             crossed
);

  // One extra bit holds q + b_eff and the modulus MAX_VAL+1 without overflow
  localparam logic [WIDTH:0] MAXV    = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] MODULUS = MAXV + ONE;

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] res;

  // Step q by b_eff in the requested direction, folding or clamping at the bounds
  always_comb begin
    q_ext   = {1'b0, q};
    b_ext   = {1'b0, b_eff};
    sum     = q_ext + b_ext;
    res     = q_ext;
    crossed = 1'b0;
    case (dir)
      CTL_UP: begin
        if (sum > MAXV) begin
          crossed = 1'b1;
          res     = (mode == MODE_SAT) ? MAXV : (sum - MODULUS);
        end else begin
          res = sum;
        end
      end
      CTL_DN: begin
        if (b_ext <= q_ext) begin
          res = q_ext - b_ext;
        end else begin
          crossed = 1'b1;
          res     = (mode == MODE_SAT) ? '0 : (q_ext + MODULUS - b_ext);
        end
      end
      default: ;
    endcase
    nxt = res[WIDTH-1:0];
  end

endmodule

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - bounded up/down counter with load, wrap/saturate mode and overflow flags
module up_down_counter_param
  import up_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             up,
  input  logic             dn,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MAXV  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_Q = MAXV[WIDTH-1:0];
  localparam logic             MODE  = SATURATE ? MODE_SAT : MODE_WRAP;

  logic [WIDTH-1:0] a_clamp;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] step_q;
  logic             step_crossed;
  ctl_e             ctl;

  // Clamp load value and step size into range; load beats counting, conflicting up/dn holds
  always_comb begin
    a_clamp = ({1'b0, a} > MAXV) ? MAX_Q : a;
    b_eff   = ({1'b0, b} > MAXV) ? MAX_Q : b;
    ctl     = CTL_HOLD;
    if (load) begin
      ctl = CTL_LOAD;
    end else if (en && (up ^ dn)) begin
      ctl = up ? CTL_UP : CTL_DN;
    end
  end

  step_unit #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .q       (q),
    .b_eff   (b_eff),
    .dir     (ctl),
    .mode    (MODE),
    .nxt     (step_q),
    .crossed (step_crossed)
  );

  // Counter, one-cycle wrap pulse and sticky overflow; a new wrap wins over clr_ovf
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (ctl)
        CTL_LOAD: begin
          q    <= a_clamp;
          wrap <= 1'b0;
        end
        CTL_UP, CTL_DN: begin
          q    <= step_q;
          wrap <= step_crossed;
        end
        default: wrap <= 1'b0;
      endcase
      ovf <= step_crossed | (ovf & ~clr_ovf);
    end
  end

  assign at_max = (q == MAX_Q);
  assign at_min = (q == '0);

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - randomized model-checked bench for up_down_counter_param
module tb_up_down_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, load = 1'b0, up = 1'b0, dn = 1'b0, clr_ovf = 1'b0;
  logic [8:0] a9 = '0, b9 = '0;

  logic [7:0] q_w, q_s;
  logic [8:0] q_n;
  logic       max_w, min_w, wrap_w, ovf_w;
  logic       max_s, min_s, wrap_s, ovf_s;
  logic       max_n, min_n, wrap_n, ovf_n;

  int checks = 0;
  int failures = 0;

  // instance 0: 8-bit wrap, 1: 8-bit saturate at 100, 2: 9-bit wrap at 300
  int maxv[3] = '{255, 100, 300};
  bit sat[3]  = '{1'b0, 1'b1, 1'b0};
  int mask[3] = '{255, 255, 511};
  int mq[3]   = '{0, 0, 0};
  bit mw[3]   = '{1'b0, 1'b0, 1'b0};
  bit mo[3]   = '{1'b0, 1'b0, 1'b0};

  up_down_counter_param #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .load(load), .a(a9[7:0]), .b(b9[7:0]), .up(up), .dn(dn),
    .clr_ovf(clr_ovf), .q(q_w), .at_max(max_w), .at_min(min_w), .wrap(wrap_w), .ovf(ovf_w));

  up_down_counter_param #(.WIDTH(8), .MAX_VAL(100), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .load(load), .a(a9[7:0]), .b(b9[7:0]), .up(up), .dn(dn),
    .clr_ovf(clr_ovf), .q(q_s), .at_max(max_s), .at_min(min_s), .wrap(wrap_s), .ovf(ovf_s));

  up_down_counter_param #(.WIDTH(9), .MAX_VAL(300), .SATURATE(1'b0)) dut_n (
    .clk(clk), .rst(rst), .en(en), .load(load), .a(a9), .b(b9), .up(up), .dn(dn),
    .clr_ovf(clr_ovf), .q(q_n), .at_max(max_n), .at_min(min_n), .wrap(wrap_n), .ovf(ovf_n));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: next value from plain integer arithmetic on the behavioural rules
  function automatic int model_next(input int q, input int av, input int bv, input bit ld,
                                    input bit e, input bit u, input bit d, input int mx,
                                    input bit s, output bit w);
    int be;
    w = 1'b0;
    if (ld) return (av > mx) ? mx : av;
    if (!e || (u == d)) return q;
    be = (bv > mx) ? mx : bv;
    if (u) begin
      if (q + be > mx) begin
        w = 1'b1;
        return s ? mx : q + be - (mx + 1);
      end
      return q + be;
    end
    if (be > q) begin
      w = 1'b1;
      return s ? 0 : q + mx + 1 - be;
    end
    return q - be;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        mq[i] <= 0;
        mw[i] <= 1'b0;
        mo[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int nq;
        bit w;
        nq = model_next(mq[i], int'(a9) & mask[i], int'(b9) & mask[i], load, en, up, dn,
                        maxv[i], sat[i], w);
        mq[i] <= nq;
        mw[i] <= w;
        mo[i] <= w | (mo[i] & !clr_ovf);
      end
    end
  end

  task automatic cmp(input int i, input int dq, input bit dmax, input bit dmin, input bit dw,
                     input bit dov);
    chk($sformatf("q[%0d]", i), dq, mq[i]);
    chk($sformatf("at_max[%0d]", i), int'(dmax), int'(mq[i] == maxv[i]));
    chk($sformatf("at_min[%0d]", i), int'(dmin), int'(mq[i] == 0));
    chk($sformatf("wrap[%0d]", i), int'(dw), int'(mw[i]));
    chk($sformatf("ovf[%0d]", i), int'(dov), int'(mo[i]));
  endtask

  // Every-cycle comparison of all three instances against the model, mid-cycle
  always @(negedge clk) begin
    cmp(0, int'(q_w), max_w, min_w, wrap_w, ovf_w);
    cmp(1, int'(q_s), max_s, min_s, wrap_s, ovf_s);
    cmp(2, int'(q_n), max_n, min_n, wrap_n, ovf_n);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b1; up = 1'b1; b9 = 9'd3;
    #12;
    chk("rst_q", int'(q_w), 0);
    chk("rst_at_min", int'(min_w), 1);
    chk("rst_wrap", int'(wrap_w), 0);
    chk("rst_ovf", int'(ovf_w), 0);
    rst = 1'b1;
    cyc();
    chk("rel_q_eq_b", int'(q_w), 3);
    chk("model_rel_q", mq[0], 3);

    load = 1'b1; a9 = 9'd250;
    cyc();
    load = 1'b0; b9 = 9'd10;
    cyc();
    chk("wrap_up_q", int'(q_w), 4);
    chk("wrap_up_pulse", int'(wrap_w), 1);
    chk("wrap_up_ovf", int'(ovf_w), 1);
    chk("model_wrap_up_q", mq[0], 4);
    en = 1'b0;
    cyc();
    chk("wrap_up_pulse_end", int'(wrap_w), 0);
    chk("wrap_up_ovf_held", int'(ovf_w), 1);

    load = 1'b1; a9 = 9'd3; en = 1'b1;
    cyc();
    load = 1'b0; up = 1'b0; dn = 1'b1; b9 = 9'd5;
    cyc();
    chk("wrap_dn_q", int'(q_w), 254);
    chk("wrap_dn_pulse", int'(wrap_w), 1);
    b9 = 9'd0;
    cyc();
    chk("b0_q", int'(q_w), 254);
    chk("b0_wrap", int'(wrap_w), 0);

    load = 1'b1; a9 = 9'd95;
    cyc();
    chk("sat_load_q", int'(q_s), 95);
    load = 1'b0; up = 1'b1; dn = 1'b0; b9 = 9'd10;
    cyc();
    chk("sat_up_q", int'(q_s), 100);
    chk("sat_up_at_max", int'(max_s), 1);
    chk("sat_up_wrap", int'(wrap_s), 1);
    cyc();
    chk("sat_again_q", int'(q_s), 100);
    chk("sat_again_wrap", int'(wrap_s), 1);
    up = 1'b0; dn = 1'b1; b9 = 9'd200;
    cyc();
    chk("sat_dn_q", int'(q_s), 0);
    chk("sat_dn_at_min", int'(min_s), 1);
    chk("sat_dn_exact_wrap", int'(wrap_s), 0);
    cyc();
    chk("sat_dn_floor_q", int'(q_s), 0);
    chk("sat_dn_floor_wrap", int'(wrap_s), 1);

    load = 1'b1; up = 1'b1; dn = 1'b0; a9 = 9'd300;
    cyc();
    chk("prio_load_q", int'(q_n), 300);
    chk("prio_at_max", int'(max_n), 1);
    load = 1'b0; dn = 1'b1; b9 = 9'd7;
    cyc();
    chk("updn_hold_q", int'(q_n), 300);
    dn = 1'b0; en = 1'b0;
    cyc();
    chk("en0_hold_q", int'(q_n), 300);
    load = 1'b1; a9 = 9'd511;
    cyc();
    chk("load_clamp_q", int'(q_n), 300);
    load = 1'b0; clr_ovf = 1'b1;
    cyc();
    chk("clr_ovf", int'(ovf_n), 0);
    en = 1'b1; b9 = 9'd1;
    cyc();
    chk("clr_vs_wrap_q", int'(q_n), 0);
    chk("clr_vs_wrap_ovf", int'(ovf_n), 1);
    en = 1'b0;
    cyc();
    chk("clr_after_ovf", int'(ovf_n), 0);
    clr_ovf = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      load    = ($urandom_range(7) == 0);
      en      = ($urandom_range(3) != 0);
      up      = 1'($urandom_range(1));
      dn      = 1'($urandom_range(1));
      clr_ovf = ($urandom_range(7) == 0);
      a9      = 9'($urandom_range(511));
      b9      = ($urandom_range(3) == 0) ? 9'($urandom_range(511)) : 9'($urandom_range(12));
      if ($urandom_range(49) == 0) begin
        #1 rst = 1'b0;
        #1;
        chk("async_rst_q_w", int'(q_w), 0);
        chk("async_rst_q_s", int'(q_s), 0);
        chk("async_rst_q_n", int'(q_n), 0);
        chk("async_rst_ovf_n", int'(ovf_n), 0);
        #1 rst = 1'b1;
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
